// File: rtl/cellrv32_wb_responder.sv
// rtl/cellrv32_wb_responder.sv - Wishbone responder backed by a word RAM with programmable wait states.
// Optional privileged upper half-window: define CELLRV32_WB_RESP_PRIV_EN.
module cellrv32_wb_responder #(
  parameter int unsigned MEM_SIZE    = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h9000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          PIPE_MODE   = 1'b0,
  parameter bit          ERR_ON_MISS = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [2:0]  wb_tag_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic        busy_o
);

  localparam int unsigned AW      = $clog2(MEM_SIZE);
  localparam int unsigned WORDS   = MEM_SIZE / 4;
  localparam int unsigned IW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [7:0]  WS_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, dat_q;
  logic        we_q, priv_q;
  logic [3:0]  sel_q;
  logic        ack_q, ack_d, err_q, err_d;
  logic        wr_en;
  logic [31:0] mem [WORDS];

  // Request attributes: the live bus while idle, the captured copy afterwards
  logic [31:0] cur_adr, cur_dat;
  logic        cur_we, cur_priv;
  logic [3:0]  cur_sel;
  assign cur_adr  = (state_q == S_IDLE) ? wb_adr_i    : adr_q;
  assign cur_dat  = (state_q == S_IDLE) ? wb_dat_i    : dat_q;
  assign cur_we   = (state_q == S_IDLE) ? wb_we_i     : we_q;
  assign cur_sel  = (state_q == S_IDLE) ? wb_sel_i    : sel_q;
  assign cur_priv = (state_q == S_IDLE) ? wb_tag_i[0] : priv_q;

  logic        hit, priv_fault;
  logic [31:0] idx_full;
  logic [IW-1:0] idx;
  assign hit      = (cur_adr >> AW) == (BASE_ADDR >> AW);
  assign idx_full = (cur_adr >> 2) & 32'(WORDS - 1);
  assign idx      = idx_full[IW-1:0];

`ifdef CELLRV32_WB_RESP_PRIV_EN
  assign priv_fault = cur_we & cur_adr[AW-1] & ~cur_priv;
`else
  assign priv_fault = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = ^{wb_tag_i[2:1], cur_adr[1:0], idx_full, cur_priv};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (!hit) begin
            if (ERR_ON_MISS) begin
              state_d = S_RESP;
              err_d   = 1'b1;
            end
          end else if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            ack_d   = ~priv_fault;
            err_d   = priv_fault;
            wr_en   = cur_we & ~priv_fault;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = S_RESP;
          ack_d   = ~priv_fault;
          err_d   = priv_fault;
          wr_en   = cur_we & ~priv_fault;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      priv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (state_q == S_IDLE) begin
        adr_q  <= wb_adr_i;
        dat_q  <= wb_dat_i;
        we_q   <= wb_we_i;
        sel_q  <= wb_sel_i;
        priv_q <= wb_tag_i[0];
      end
    end
  end

  // RAM is deliberately not reset; a write never lands while reset is asserted
  always_ff @(posedge clk_i) begin
    if (wr_en && rstn_i) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  assign wb_dat_o   = ack_q ? mem[idx] : '0;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign busy_o     = (state_q != S_IDLE);
  assign wb_stall_o = PIPE_MODE & (state_q != S_IDLE);

endmodule
